// File: rtl/baud_div_pkg.sv
// Shared constants and helpers for the multi-byte baud divisor generator:
// register map offsets, byte-count derivation and divisor-width legality.
package baud_div_pkg;

  localparam int unsigned LS_OFFSET = 0;

  typedef enum logic [1:0] {
    SEL_NONE,
    SEL_BYTE,
    SEL_STATUS
  } rd_sel_e;

  function automatic int unsigned nbytes(input int unsigned div_width);
    return div_width / 8;
  endfunction

  // Status byte sits immediately above the MS divisor byte.
  function automatic int unsigned status_offset(input int unsigned div_width);
    return nbytes(div_width);
  endfunction

  function automatic bit div_width_ok(input int unsigned div_width);
    return (div_width >= 8) && (div_width <= 32) && (div_width % 8 == 0);
  endfunction

endpackage

// File: rtl/baud_tick_counter.sv
// Live divisor, down-counter and registered baud_tick strobe. A commit
// reloads divisor and count together so a new rate starts on a clean period.
module baud_tick_counter #(
  parameter int unsigned          DIV_WIDTH = 16,
  parameter logic [DIV_WIDTH-1:0] RESET_DIV = '0
) (
  input  logic                 m_clk,
  input  logic                 reset,
  input  logic                 commit,
  input  logic [DIV_WIDTH-1:0] commit_value,
  output logic [DIV_WIDTH-1:0] divisor,
  output logic                 baud_tick,
  output logic                 boundary
);

  localparam logic [DIV_WIDTH-1:0] ONE = DIV_WIDTH'(1);
  localparam logic [DIV_WIDTH-1:0] RESET_CNT = (RESET_DIV == '0) ? '0 : RESET_DIV - ONE;

  logic [DIV_WIDTH-1:0] div_q, div_d;
  logic [DIV_WIDTH-1:0] cnt_q, cnt_d;
  logic                 tick_q;
  logic                 tick;

  always_comb begin
    tick  = (div_q != '0) && (cnt_q == '0);
    div_d = div_q;
    cnt_d = cnt_q;
    if (commit) begin
      div_d = commit_value;
      cnt_d = (commit_value == '0) ? '0 : commit_value - ONE;
    end else if (tick) begin
      cnt_d = div_q - ONE;
    end else if (div_q != '0) begin
      cnt_d = cnt_q - ONE;
    end
  end

  always_ff @(posedge m_clk) begin
    if (reset) begin
      div_q  <= RESET_DIV;
      cnt_q  <= RESET_CNT;
      tick_q <= 1'b0;
    end else begin
      div_q  <= div_d;
      cnt_q  <= cnt_d;
      tick_q <= tick;
    end
  end

  // A disabled generator is always at a boundary; otherwise only at count zero.
  assign boundary  = (div_q == '0) || (cnt_q == '0);
  assign divisor   = div_q;
  assign baud_tick = tick_q;

endmodule

// File: rtl/baud_divisor_gen.sv
// Register-bus front end: bytewise shadow divisor, pending flag, readback and
// atomic commit of the shadow into the tick counter at a period boundary.
module baud_divisor_gen
  import baud_div_pkg::*;
#(
  parameter int unsigned           DIV_WIDTH  = 16,
  parameter int unsigned           ADDR_WIDTH = 16,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = 16'h0030,
  parameter logic [DIV_WIDTH-1:0]  RESET_DIV  = '0
) (
  input  logic                  m_clk,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] address,
  input  logic [7:0]            data_in,
  input  logic                  wr_en,
  input  logic                  rd_en,
  output logic [7:0]            rd_data,
  output logic [DIV_WIDTH-1:0]  divisor,
  output logic                  baud_tick,
  output logic                  update_pending
);

  localparam int unsigned NBYTES = nbytes(DIV_WIDTH);
  localparam logic [ADDR_WIDTH-1:0] STATUS_ADDR =
    BASE_ADDR + ADDR_WIDTH'(status_offset(DIV_WIDTH));

  if (!div_width_ok(DIV_WIDTH)) begin : g_bad_width
    $error("baud_divisor_gen: DIV_WIDTH must be a multiple of 8 in 8..32");
  end

  logic [NBYTES-1:0][7:0] shadow_q, shadow_d;
  logic                   pending_q, pending_d;
  logic [7:0]             rd_data_q, rd_data_d;
  logic [NBYTES-1:0]      byte_hit;
  logic                   status_hit;
  logic                   boundary;
  logic                   commit;
  rd_sel_e                rd_sel;
  logic [7:0]             rd_byte;

  always_comb begin
    byte_hit = '0;
    for (int k = 0; k < NBYTES; k++) begin
      byte_hit[k] = (address == BASE_ADDR + ADDR_WIDTH'(LS_OFFSET + k));
    end
    status_hit = (address == STATUS_ADDR);
  end

  assign commit = pending_q && boundary;

  // An MS-byte write coinciding with a commit re-arms pending for the next boundary.
  always_comb begin
    shadow_d  = shadow_q;
    pending_d = pending_q;
    if (commit) pending_d = 1'b0;
    if (wr_en) begin
      for (int k = 0; k < NBYTES; k++) begin
        if (byte_hit[k]) shadow_d[k] = data_in;
      end
      if (byte_hit[NBYTES-1]) pending_d = 1'b1;
    end
  end

  always_comb begin
    rd_sel  = SEL_NONE;
    rd_byte = '0;
    for (int k = 0; k < NBYTES; k++) begin
      if (byte_hit[k]) begin
        rd_sel  = SEL_BYTE;
        rd_byte = shadow_q[k];
      end
    end
    if (status_hit) rd_sel = SEL_STATUS;
    rd_data_d = '0;
    if (rd_en) begin
      case (rd_sel)
        SEL_BYTE:   rd_data_d = rd_byte;
        SEL_STATUS: rd_data_d = {7'b0, pending_q};
        default:    rd_data_d = '0;
      endcase
    end
  end

  always_ff @(posedge m_clk) begin
    if (reset) begin
      shadow_q  <= RESET_DIV;
      pending_q <= 1'b0;
      rd_data_q <= '0;
    end else begin
      shadow_q  <= shadow_d;
      pending_q <= pending_d;
      rd_data_q <= rd_data_d;
    end
  end

  baud_tick_counter #(
    .DIV_WIDTH (DIV_WIDTH),
    .RESET_DIV (RESET_DIV)
  ) u_counter (
    .m_clk        (m_clk),
    .reset        (reset),
    .commit       (commit),
    .commit_value (shadow_q),
    .divisor      (divisor),
    .baud_tick    (baud_tick),
    .boundary     (boundary)
  );

  assign rd_data        = rd_data_q;
  assign update_pending = pending_q;

endmodule

// File: tb/tb_baud_divisor_gen.sv
// Bench for baud_divisor_gen: directed scenarios plus randomized bus traffic
// against an edge-scheduling reference model; second instance covers 24-bit.
module tb_baud_divisor_gen;

  logic        m_clk = 1'b0;
  logic        reset;
  logic [15:0] address;
  logic [7:0]  data_in;
  logic        wr_en, rd_en;
  logic [7:0]  rd_data;
  logic [15:0] divisor;
  logic        baud_tick, update_pending;

  logic        reset24;
  logic [15:0] address24;
  logic [7:0]  data_in24;
  logic        wr_en24, rd_en24;
  logic [7:0]  rd_data24;
  logic [23:0] divisor24;
  logic        baud_tick24, update_pending24;

  int checks = 0;
  int errors = 0;

  always #5 m_clk = ~m_clk;

  baud_divisor_gen #(
    .DIV_WIDTH(16), .ADDR_WIDTH(16), .BASE_ADDR(16'h0030), .RESET_DIV(16'h0000)
  ) dut (
    .m_clk(m_clk), .reset(reset), .address(address), .data_in(data_in),
    .wr_en(wr_en), .rd_en(rd_en), .rd_data(rd_data), .divisor(divisor),
    .baud_tick(baud_tick), .update_pending(update_pending)
  );

  baud_divisor_gen #(
    .DIV_WIDTH(24), .ADDR_WIDTH(16), .BASE_ADDR(16'h0030), .RESET_DIV(24'h000000)
  ) dut24 (
    .m_clk(m_clk), .reset(reset24), .address(address24), .data_in(data_in24),
    .wr_en(wr_en24), .rd_en(rd_en24), .rd_data(rd_data24), .divisor(divisor24),
    .baud_tick(baud_tick24), .update_pending(update_pending24)
  );

  // Reference model for the 16-bit instance: ticks are scheduled as absolute
  // edge numbers (next tick edge = commit/tick edge + divisor).
  int unsigned m_shadow = 0, m_div = 0, m_rd = 0;
  bit          m_pend = 0, m_tick = 0;
  longint      e_now = 0, m_next = 0;

  always @(posedge m_clk) begin
    int unsigned old_sh;
    bit t, c;
    if (reset) begin
      m_shadow = 0; m_div = 0; m_pend = 0; m_tick = 0; m_rd = 0; m_next = 0;
    end else begin
      t = (m_div != 0) && (e_now == m_next);
      c = m_pend && ((m_div == 0) || t);
      old_sh = m_shadow;
      m_rd = 0;
      if (rd_en) begin
        if (address == 16'h0030)      m_rd = old_sh & 32'hff;
        else if (address == 16'h0031) m_rd = (old_sh >> 8) & 32'hff;
        else if (address == 16'h0032) m_rd = {31'b0, m_pend};
      end
      if (c) begin
        m_div = old_sh; m_next = e_now + longint'(old_sh); m_pend = 0;
      end else if (t) begin
        m_next = e_now + longint'(m_div);
      end
      if (wr_en && address == 16'h0030) m_shadow = (m_shadow & 32'hff00) | int'(data_in);
      if (wr_en && address == 16'h0031) begin
        m_shadow = (m_shadow & 32'h00ff) | (int'(data_in) << 8);
        m_pend = 1;
      end
      m_tick = t;
    end
    e_now++;
  end

  task automatic cyc(input logic [15:0] a, input logic [7:0] d, input bit w, input bit r);
    address = a; data_in = d; wr_en = w; rd_en = r;
    @(posedge m_clk);
    @(negedge m_clk);
  endtask

  task automatic cyc24(input logic [15:0] a, input logic [7:0] d, input bit w, input bit r);
    address24 = a; data_in24 = d; wr_en24 = w; rd_en24 = r;
    @(posedge m_clk);
    @(negedge m_clk);
  endtask

  task automatic wait_tick(input int bound, output bit ok);
    ok = 0;
    for (int i = 0; i < bound && !ok; i++) begin
      cyc(16'h0, 8'h0, 0, 0);
      ok = baud_tick;
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    cyc(16'h0, 8'h0, 0, 0);
    cyc(16'h0, 8'h0, 0, 0);
    reset = 1'b0;
    for (int i = 0; i < 20; i++) begin
      cyc(16'h0, 8'h0, 0, 0);
      checks++;
      if (divisor !== 16'h0 || baud_tick !== 1'b0 || rd_data !== 8'h0 || update_pending !== 1'b0) begin
        errors++;
        $display("FAIL reset_idle cyc %0d: div=%h tick=%b rd=%h pend=%b, want 0/0/0/0",
                 i, divisor, baud_tick, rd_data, update_pending);
      end
    end
  endtask

  task automatic test_first_commit;
    bit exp;
    cyc(16'h0030, 8'h04, 1, 0);
    cyc(16'h0031, 8'h00, 1, 0);
    checks++;
    if (update_pending !== 1'b1) begin
      errors++; $display("FAIL first_pending: got %b want 1", update_pending);
    end
    checks++;
    if (divisor !== 16'h0) begin
      errors++; $display("FAIL first_div_before: got %h want 0", divisor);
    end
    for (int j = 1; j <= 14; j++) begin
      cyc(16'h0, 8'h0, 0, 0);
      exp = (j + 1 == 6) || (j + 1 == 10) || (j + 1 == 14);
      checks++;
      if (baud_tick !== exp) begin
        errors++; $display("FAIL first_tick cycle %0d: got %b want %b", j + 1, baud_tick, exp);
      end
    end
    checks++;
    if (divisor !== 16'd4) begin
      errors++; $display("FAIL first_div: got %h want 4", divisor);
    end
  endtask

  task automatic test_midperiod_change;
    bit ok;
    wait_tick(8, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL mid_sync: no tick within 8 cycles, want tick"); end
    cyc(16'h0030, 8'h0A, 1, 0);
    cyc(16'h0031, 8'h00, 1, 0);
    checks++;
    if (update_pending !== 1'b1) begin errors++; $display("FAIL mid_pend_a: got %b want 1", update_pending); end
    cyc(16'h0, 8'h0, 0, 0);
    checks++;
    if (update_pending !== 1'b1 || divisor !== 16'd4) begin
      errors++; $display("FAIL mid_pend_b: pend=%b div=%h want 1/4", update_pending, divisor);
    end
    cyc(16'h0, 8'h0, 0, 0);
    checks++;
    if (baud_tick !== 1'b1 || divisor !== 16'd10 || update_pending !== 1'b0) begin
      errors++; $display("FAIL mid_commit: tick=%b div=%h pend=%b want 1/a/0", baud_tick, divisor, update_pending);
    end
    for (int k = 1; k <= 10; k++) begin
      cyc(16'h0, 8'h0, 0, 0);
      checks++;
      if (baud_tick !== (k == 10)) begin
        errors++; $display("FAIL mid_spacing k=%0d: got %b want %b", k, baud_tick, (k == 10));
      end
    end
  endtask

  task automatic test_readback;
    bit ok;
    wait_tick(12, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL rb_sync: no tick within 12 cycles, want tick"); end
    cyc(16'h0030, 8'h0A, 1, 0);
    cyc(16'h0031, 8'h00, 1, 0);
    cyc(16'h0030, 8'h00, 0, 1);
    checks++;
    if (rd_data !== 8'h0A) begin errors++; $display("FAIL rb_byte0: got %h want 0a", rd_data); end
    cyc(16'h0031, 8'h00, 0, 1);
    checks++;
    if (rd_data !== 8'h00) begin errors++; $display("FAIL rb_byte1: got %h want 00", rd_data); end
    cyc(16'h0032, 8'h00, 0, 1);
    checks++;
    if (rd_data !== 8'h01) begin errors++; $display("FAIL rb_status: got %h want 01", rd_data); end
    cyc(16'h0040, 8'h00, 0, 1);
    checks++;
    if (rd_data !== 8'h00) begin errors++; $display("FAIL rb_unmapped: got %h want 00", rd_data); end
    cyc(16'h0030, 8'h00, 0, 0);
    checks++;
    if (rd_data !== 8'h00) begin errors++; $display("FAIL rb_no_rden: got %h want 00", rd_data); end
    cyc(16'h0030, 8'h07, 1, 1);
    checks++;
    if (rd_data !== 8'h0A) begin errors++; $display("FAIL rb_rw_same: got %h want 0a", rd_data); end
    cyc(16'h0, 8'h0, 0, 0);
    cyc(16'h0, 8'h0, 0, 0);
    checks++;
    if (divisor !== 16'd7 || update_pending !== 1'b0) begin
      errors++; $display("FAIL rb_lower_included: div=%h pend=%b want 7/0", divisor, update_pending);
    end
  endtask

  task automatic test_same_cycle;
    bit ok;
    wait_tick(10, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL sc_sync: no tick within 10 cycles, want tick"); end
    cyc(16'h0030, 8'h05, 1, 0);
    cyc(16'h0031, 8'h00, 1, 0);
    for (int i = 0; i < 4; i++) cyc(16'h0, 8'h0, 0, 0);
    cyc(16'h0031, 8'h01, 1, 0);
    checks++;
    if (divisor !== 16'd5 || update_pending !== 1'b1 || baud_tick !== 1'b1) begin
      errors++; $display("FAIL sc_commit_old: div=%h pend=%b tick=%b want 5/1/1", divisor, update_pending, baud_tick);
    end
    for (int i = 0; i < 4; i++) begin
      cyc(16'h0, 8'h0, 0, 0);
      checks++;
      if (update_pending !== 1'b1 || divisor !== 16'd5) begin
        errors++; $display("FAIL sc_wait %0d: pend=%b div=%h want 1/5", i, update_pending, divisor);
      end
    end
    cyc(16'h0, 8'h0, 0, 0);
    checks++;
    if (divisor !== 16'h0105 || update_pending !== 1'b0 || baud_tick !== 1'b1) begin
      errors++; $display("FAIL sc_commit_new: div=%h pend=%b tick=%b want 105/0/1", divisor, update_pending, baud_tick);
    end
  endtask

  task automatic test_div_one;
    bit ok;
    cyc(16'h0030, 8'h01, 1, 0);
    cyc(16'h0031, 8'h00, 1, 0);
    ok = 0;
    for (int i = 0; i < 300 && !ok; i++) begin
      cyc(16'h0, 8'h0, 0, 0);
      ok = (divisor === 16'd1);
    end
    checks++;
    if (!ok) begin errors++; $display("FAIL one_commit: div=%h after 300 cycles, want 1", divisor); end
    for (int i = 0; i < 10; i++) begin
      cyc(16'h0, 8'h0, 0, 0);
      checks++;
      if (baud_tick !== 1'b1) begin errors++; $display("FAIL one_tick %0d: got %b want 1", i, baud_tick); end
    end
  endtask

  task automatic test_div_zero;
    bit ok;
    cyc(16'h0030, 8'h00, 1, 0);
    cyc(16'h0031, 8'h00, 1, 0);
    ok = 0;
    for (int i = 0; i < 5 && !ok; i++) begin
      cyc(16'h0, 8'h0, 0, 0);
      ok = (divisor === 16'd0);
    end
    checks++;
    if (!ok) begin errors++; $display("FAIL zero_commit: div=%h after 5 cycles, want 0", divisor); end
    checks++;
    if (baud_tick !== 1'b1) begin errors++; $display("FAIL zero_last_tick: got %b want 1", baud_tick); end
    for (int i = 0; i < 10; i++) begin
      cyc(16'h0, 8'h0, 0, 0);
      checks++;
      if (baud_tick !== 1'b0 || dut.u_counter.cnt_q !== 16'h0) begin
        errors++; $display("FAIL zero_hold %0d: tick=%b cnt=%h want 0/0", i, baud_tick, dut.u_counter.cnt_q);
      end
    end
  endtask

  task automatic test_reset_pending;
    bit ok;
    cyc(16'h0030, 8'h06, 1, 0);
    cyc(16'h0031, 8'h00, 1, 0);
    wait_tick(12, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL rstp_sync: no tick within 12 cycles, want tick"); end
    cyc(16'h0030, 8'h09, 1, 0);
    cyc(16'h0031, 8'h00, 1, 0);
    checks++;
    if (update_pending !== 1'b1) begin errors++; $display("FAIL rstp_pend: got %b want 1", update_pending); end
    reset = 1'b1;
    cyc(16'h0032, 8'h00, 0, 1);
    reset = 1'b0;
    checks++;
    if (divisor !== 16'h0 || baud_tick !== 1'b0 || update_pending !== 1'b0 || rd_data !== 8'h0) begin
      errors++; $display("FAIL rstp_now: div=%h tick=%b pend=%b rd=%h want 0/0/0/0",
                         divisor, baud_tick, update_pending, rd_data);
    end
    for (int i = 0; i < 10; i++) begin
      cyc(16'h0, 8'h0, 0, 0);
      checks++;
      if (divisor !== 16'h0 || baud_tick !== 1'b0) begin
        errors++; $display("FAIL rstp_after %0d: div=%h tick=%b want 0/0", i, divisor, baud_tick);
      end
    end
  endtask

  task automatic test_random;
    logic [15:0] a;
    logic [7:0]  d;
    for (int i = 0; i < 500; i++) begin
      a = 16'h002F + 16'($urandom_range(0, 4));
      if (a == 16'h0031) d = ($urandom_range(0, 9) == 0) ? 8'h01 : 8'h00;
      else               d = 8'($urandom_range(0, 12));
      reset = ($urandom_range(0, 149) == 0);
      cyc(a, d, $urandom_range(0, 2) == 0, $urandom_range(0, 1) == 1);
      reset = 1'b0;
      checks++;
      if (divisor !== 16'(m_div) || baud_tick !== m_tick || update_pending !== m_pend || rd_data !== 8'(m_rd)) begin
        errors++;
        $display("FAIL rand %0d: div=%h tick=%b pend=%b rd=%h want %h/%b/%b/%h",
                 i, divisor, baud_tick, update_pending, rd_data, 16'(m_div), m_tick, m_pend, 8'(m_rd));
      end
    end
  endtask

  task automatic test_w24;
    reset24 = 1'b0;
    cyc24(16'h0030, 8'h03, 1, 0);
    cyc24(16'h0031, 8'h00, 1, 0);
    checks++;
    if (update_pending24 !== 1'b0) begin errors++; $display("FAIL w24_mid_byte: pend=%b want 0", update_pending24); end
    cyc24(16'h0032, 8'h00, 1, 0);
    checks++;
    if (update_pending24 !== 1'b1 || divisor24 !== 24'h0) begin
      errors++; $display("FAIL w24_ms: pend=%b div=%h want 1/0", update_pending24, divisor24);
    end
    cyc24(16'h0033, 8'h00, 0, 1);
    checks++;
    if (rd_data24 !== 8'h01 || divisor24 !== 24'd3 || update_pending24 !== 1'b0) begin
      errors++; $display("FAIL w24_commit: rd=%h div=%h pend=%b want 01/3/0", rd_data24, divisor24, update_pending24);
    end
    for (int e = 2; e <= 7; e++) begin
      cyc24(16'h0, 8'h0, 0, 0);
      checks++;
      if (baud_tick24 !== (e == 4 || e == 7)) begin
        errors++; $display("FAIL w24_tick edge %0d: got %b want %b", e, baud_tick24, (e == 4 || e == 7));
      end
    end
    cyc24(16'h0032, 8'h10, 1, 0);
    checks++;
    if (update_pending24 !== 1'b1) begin errors++; $display("FAIL w24_pend: got %b want 1", update_pending24); end
    reset24 = 1'b1;
    cyc24(16'h0, 8'h0, 0, 0);
    reset24 = 1'b0;
    checks++;
    if (divisor24 !== 24'h0 || update_pending24 !== 1'b0 || baud_tick24 !== 1'b0 || rd_data24 !== 8'h0) begin
      errors++; $display("FAIL w24_reset: div=%h pend=%b tick=%b rd=%h want 0/0/0/0",
                         divisor24, update_pending24, baud_tick24, rd_data24);
    end
    for (int i = 0; i < 5; i++) begin
      cyc24(16'h0, 8'h0, 0, 0);
      checks++;
      if (divisor24 !== 24'h0 || baud_tick24 !== 1'b0) begin
        errors++; $display("FAIL w24_after %0d: div=%h tick=%b want 0/0", i, divisor24, baud_tick24);
      end
    end
  endtask

  initial begin
    reset = 1'b1; address = '0; data_in = '0; wr_en = 1'b0; rd_en = 1'b0;
    reset24 = 1'b1; address24 = '0; data_in24 = '0; wr_en24 = 1'b0; rd_en24 = 1'b0;
    test_reset();
    test_first_commit();
    test_midperiod_change();
    test_readback();
    test_same_cycle();
    test_div_one();
    test_div_zero();
    test_reset_pending();
    test_random();
    test_w24();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
